// File: rtl/seq_add_pkg.sv
// Shared types and helpers for the sequential wide adder.
//   seq_add_state_e : controller FSM encoding (IDLE, RUN, DONE)
//   beat_w()        : width of the beat counter for a given beat count
package seq_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_add_state_e;

   // max(1, clog2(beats)) so a single-beat build still has a 1-bit counter
   function automatic int unsigned beat_w(input int beats);
      if (beats <= 1) return 1;
      return int'($clog2(beats));
   endfunction

endpackage : seq_add_pkg

// File: rtl/rc_adder_slice.sv
// N-bit ripple-carry adder slice, purely combinational.
// Ports:
//   a_i, b_i [N-1:0] : addends
//   c_i              : carry in
//   s_o      [N-1:0] : sum
//   c_o              : carry out of bit N-1
module rc_adder_slice #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         c_i,
   output logic [N-1:0] s_o,
   output logic         c_o
);

   logic [N:0] carry;

   // Bit-serial carry chain, one full adder per bit
   always_comb begin
      carry    = '0;
      s_o      = '0;
      carry[0] = c_i;
      for (int i = 0; i < int'(N); i++) begin
         s_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
         carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
      end
   end

   assign c_o = carry[N];

endmodule : rc_adder_slice

// File: rtl/seq_wide_adder_ctrl.sv
// Sequencer computing a W-bit add over W/N cycles on one N-bit adder slice,
// least significant slice first, carry registered between beats.
// Optional feature: define SEQ_ADD_SUB_EN to add in_sub (A-B mode).
// Ports:
//   clk, rst_n               : clock, async active-low reset
//   in_valid/in_ready        : operand handshake (in_ready only in IDLE)
//   in_a, in_b, in_cin       : operands and carry-in
//   in_sub                   : subtract select (SEQ_ADD_SUB_EN only)
//   out_valid/out_ready      : result handshake (out_valid only in DONE)
//   out_sum, out_cout        : (A+B+cin) mod 2^W and carry out
//   busy                     : controller not idle
module seq_wide_adder_ctrl
   import seq_add_pkg::*;
#(
   parameter int unsigned W = 32,
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_cin,
`ifdef SEQ_ADD_SUB_EN
   input  logic         in_sub,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_cout,
   output logic         busy
);

   localparam int unsigned BEATS = W / N;
   localparam int unsigned BW    = beat_w(int'(BEATS));

   // Elaboration-time parameter sanity check
   if ((W % N) != 0 || W < N) begin : g_bad_cfg
      $error("seq_wide_adder_ctrl: W must be a nonzero multiple of N");
   end

   seq_add_state_e state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic           c_q, c_d;
   logic [W-1:0]   sum_q, sum_d;
   logic           cout_q, cout_d;
   logic [BW-1:0]  beat_q, beat_d;

   logic [N-1:0]   slice_s;
   logic           slice_c;
   logic [W-1:0]   b_op;
   logic           cin_op;
   logic           last_beat;

   // Operand B / carry-in as captured at accept
`ifdef SEQ_ADD_SUB_EN
   assign b_op   = in_sub ? ~in_b : in_b;
   assign cin_op = in_sub ? 1'b1  : in_cin;
`else
   assign b_op   = in_b;
   assign cin_op = in_cin;
`endif

   rc_adder_slice #(.N(N)) u_slice (
      .a_i (a_q[N-1:0]),
      .b_i (b_q[N-1:0]),
      .c_i (c_q),
      .s_o (slice_s),
      .c_o (slice_c)
   );

   assign last_beat = (beat_q == BW'(BEATS - 1));

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = b_op;
               c_d     = cin_op;
               beat_d  = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // New slice enters at the top; after BEATS shifts it sits in place
            sum_d = W'({slice_s, sum_q} >> N);
            a_d   = a_q >> N;
            b_d   = b_q >> N;
            c_d   = slice_c;
            if (last_beat) begin
               cout_d  = slice_c;
               state_d = DONE;
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         beat_q  <= beat_d;
      end
   end

   // Status outputs are direct decodes of the state register
   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;

endmodule : seq_wide_adder_ctrl
